// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_I    = 2'd1,
        R_D    = 2'd2
    } resp_owner_t;

    // Starvation counter width: must be able to hold the limit itself.
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: data has priority unless fetch has waited
// through STARVE_LIMIT consecutive data grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = starve_cnt_width(STARVE_LIMIT_DEF)
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             i_gnt,
    output logic             d_gnt
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    // Priority decision with starvation override.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (i_req && (!d_req || (starve_cnt == LIMIT_C))) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the core's fetch and data
// ports; read data is routed back to its requester one cycle after the grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [XLEN-1:0] d_mask,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_mask,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int               CW      = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0]    LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic [XLEN-1:0]  ZERO_W  = {XLEN{1'b0}};

    logic [CW-1:0] r_starve_cnt;
    resp_owner_t   r_resp_owner;
    resp_owner_t   w_resp_next;
    logic          w_pick_i;
    logic          w_pick_d;
    logic          w_i_gnt;
    logic          w_d_gnt;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CW)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (r_starve_cnt),
        .i_gnt      (w_pick_i),
        .d_gnt      (w_pick_d)
    );

    // Reset suppresses any grant, so nothing reaches the memory during reset.
    assign w_i_gnt = w_pick_i & ~reset;
    assign w_d_gnt = w_pick_d & ~reset;
    assign i_gnt   = w_i_gnt;
    assign d_gnt   = w_d_gnt;

    // Memory request mux; idle cycles drive an all-zero request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ZERO_W;
        mem_wdata = ZERO_W;
        mem_mask  = ZERO_W;
        if (w_i_gnt) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_mask  = d_mask;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Starvation counter: counts data wins while fetch waits, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= {CW{1'b0}};
        end else if (w_i_gnt || !i_req) begin
            r_starve_cnt <= {CW{1'b0}};
        end else if (w_d_gnt && (r_starve_cnt != LIMIT_C)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Response owner state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_owner <= R_NONE;
        end else begin
            r_resp_owner <= w_resp_next;
        end
    end

    // Next owner: whoever was granted a read this cycle; stores expect no data.
    always_comb begin
        w_resp_next = R_NONE;
        if (w_i_gnt) begin
            w_resp_next = R_I;
        end else if (w_d_gnt && !d_we) begin
            w_resp_next = R_D;
        end else begin
            w_resp_next = R_NONE;
        end
    end

    // Response routing; reset masks a read that was granted just before it.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        case (r_resp_owner)
            R_I:     i_rvalid = ~reset;
            R_D:     d_rvalid = ~reset;
            R_NONE:  i_rvalid = 1'b0;
            default: d_rvalid = 1'b0;
        endcase
        i_rdata = i_rvalid ? mem_rdata : ZERO_W;
        d_rdata = d_rvalid ? mem_rdata : ZERO_W;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run scored against a cycle-level behavioural model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int SL   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_mask;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_mask;
    logic [XLEN-1:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_mask = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
                fails++; $display("FAIL reset_grants: got %b want 0000", {i_gnt, d_gnt, mem_en, mem_we});
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_mask} !== 96'h0) begin
                fails++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata, mem_mask});
            end
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        settle();
        checks++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
            fails++; $display("FAIL reset_resp: got %h want 0", {i_rvalid, d_rvalid, i_rdata, d_rdata});
        end
        checks++;
        if (dut.r_starve_cnt !== 3'd0) begin
            fails++; $display("FAIL reset_starve_cnt: got %0d want 0", dut.r_starve_cnt);
        end
        next_cycle();
    endtask

    task automatic test_fetch_only();
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        settle();
        checks++;
        if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h100) begin
            fails++; $display("FAIL fetch_grant: got gnt/en/we=%b addr=%h want 1010 addr=100",
                              {i_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        next_cycle();
        i_req = 1'b0; mem_rdata = 32'h0000_0013;
        settle();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h13 || d_rvalid !== 1'b0) begin
            fails++; $display("FAIL fetch_resp: got iv=%b id=%h dv=%b want 1 13 0", i_rvalid, i_rdata, d_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_store();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_mask = 32'h0000_FFFF;
        settle();
        checks++;
        if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_mask !== 32'h0000_FFFF ||
            mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
            fails++; $display("FAIL store_issue: got gnt/en/we=%b mask=%h wd=%h addr=%h",
                              {d_gnt, mem_en, mem_we}, mem_mask, mem_wdata, mem_addr);
        end
        next_cycle();
        idle_inputs(); mem_rdata = 32'h5555_AAAA;
        settle();
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            fails++; $display("FAIL store_no_resp: got iv=%b dv=%b dd=%h want 0 0 0", i_rvalid, d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp_i;
        do_reset();
        i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        for (int c = 0; c < 10; c++) begin
            exp_i = ((c % (SL + 1)) == SL);
            settle();
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                fails++; $display("FAIL contention_c%0d: got i=%b d=%b want i=%b", c, i_gnt, d_gnt, exp_i);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        settle();
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 32'h300) begin
            fails++; $display("FAIL b2b_c0: got d=%b i=%b addr=%h want 1 0 300", d_gnt, i_gnt, mem_addr);
        end
        next_cycle();
        d_req = 1'b0; mem_rdata = 32'hAAAA_0001;
        settle();
        checks++;
        if (i_gnt !== 1'b1 || mem_addr !== 32'h104 || d_rvalid !== 1'b1 ||
            d_rdata !== 32'hAAAA_0001 || i_rvalid !== 1'b0) begin
            fails++; $display("FAIL b2b_c1: got ig=%b addr=%h dv=%b dd=%h iv=%b", i_gnt, mem_addr, d_rvalid, d_rdata, i_rvalid);
        end
        next_cycle();
        i_req = 1'b0; mem_rdata = 32'hBBBB_0002;
        settle();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hBBBB_0002 || d_rvalid !== 1'b0) begin
            fails++; $display("FAIL b2b_c2: got iv=%b id=%h dv=%b", i_rvalid, i_rdata, d_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        settle();
        checks++;
        if (d_gnt !== 1'b1) begin
            fails++; $display("FAIL rmid_grant: got d=%b want 1", d_gnt);
        end
        next_cycle();
        reset = 1'b1; mem_rdata = 32'h77;
        settle();
        checks++;
        if ({d_rvalid, i_rvalid, i_gnt, d_gnt, mem_en} !== 5'b00000 || d_rdata !== 32'h0) begin
            fails++; $display("FAIL rmid_gated: got dv/iv/ig/dg/en=%b dd=%h want 0", {d_rvalid, i_rvalid, i_gnt, d_gnt, mem_en}, d_rdata);
        end
        next_cycle();
        reset = 1'b0; idle_inputs();
        settle();
        checks++;
        if (dut.r_starve_cnt !== 3'd0 || d_rvalid !== 1'b0) begin
            fails++; $display("FAIL rmid_after: got cnt=%0d dv=%b want 0 0", dut.r_starve_cnt, d_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_withdrawn();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; i_req = 1'b1; i_addr = 32'h90;
        settle();
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b1) begin
            fails++; $display("FAIL wd_c0: got i=%b d=%b want 0 1", i_gnt, d_gnt);
        end
        next_cycle();
        i_req = 1'b0;
        settle();
        checks++;
        if (i_gnt !== 1'b0 || dut.r_starve_cnt !== 3'd1) begin
            fails++; $display("FAIL wd_c1: got i=%b cnt=%0d want 0 1", i_gnt, dut.r_starve_cnt);
        end
        next_cycle();
        settle();
        checks++;
        if (i_gnt !== 1'b0 || dut.r_starve_cnt !== 3'd0) begin
            fails++; $display("FAIL wd_c2: got i=%b cnt=%0d want 0 0", i_gnt, dut.r_starve_cnt);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    // Random traffic scored against a plain arithmetic model of the rules.
    task automatic test_random();
        int  waited     = 0;   // data wins in a row while fetch was waiting
        int  prev_read  = 0;   // 0 none, 1 fetch read, 2 data read, granted last cycle
        bit  pend_i     = 0;
        bit  pend_d     = 0;
        bit  exp_i, exp_d, in_rst;
        logic [XLEN-1:0] e_addr, e_wd, e_mask;
        logic e_we;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_rst = ($urandom_range(0, 99) == 0);
            reset  = in_rst;
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; i_addr = $urandom & 32'hFFFF_FFFC;
            end else if (pend_i && $urandom_range(0, 19) == 0) begin
                pend_i = 0;
            end
            if (!pend_d && $urandom_range(0, 2) != 0) begin
                pend_d = 1; d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_wdata = $urandom; d_mask = $urandom;
            end else if (pend_d && $urandom_range(0, 19) == 0) begin
                pend_d = 0;
            end
            i_req = pend_i; d_req = pend_d;
            mem_rdata = $urandom;

            exp_i = !in_rst && pend_i && (!pend_d || waited >= SL);
            exp_d = !in_rst && pend_d && !exp_i;
            e_we   = exp_d ? d_we : 1'b0;
            e_addr = exp_i ? i_addr : (exp_d ? d_addr : 32'h0);
            e_wd   = exp_d ? d_wdata : 32'h0;
            e_mask = exp_d ? d_mask : 32'h0;

            settle();
            checks++;
            if ({i_gnt, d_gnt, mem_en, mem_we} !== {exp_i, exp_d, exp_i | exp_d, e_we}) begin
                fails++; $display("FAIL rnd_grant_c%0d: got %b want %b", c, {i_gnt, d_gnt, mem_en, mem_we}, {exp_i, exp_d, exp_i | exp_d, e_we});
            end
            checks++;
            if (mem_addr !== e_addr || mem_wdata !== e_wd || mem_mask !== e_mask) begin
                fails++; $display("FAIL rnd_bus_c%0d: got %h/%h/%h want %h/%h/%h", c, mem_addr, mem_wdata, mem_mask, e_addr, e_wd, e_mask);
            end
            checks++;
            if (i_rvalid !== (!in_rst && prev_read == 1) || d_rvalid !== (!in_rst && prev_read == 2) ||
                i_rdata !== ((!in_rst && prev_read == 1) ? mem_rdata : 32'h0) ||
                d_rdata !== ((!in_rst && prev_read == 2) ? mem_rdata : 32'h0)) begin
                fails++; $display("FAIL rnd_resp_c%0d: got iv=%b dv=%b id=%h dd=%h prev=%0d", c, i_rvalid, d_rvalid, i_rdata, d_rdata, prev_read);
            end

            if (in_rst || exp_i || !pend_i) waited = 0;
            else if (exp_d) waited = (waited + 1 > SL) ? SL : waited + 1;
            prev_read = in_rst ? 0 : (exp_i ? 1 : ((exp_d && !d_we) ? 2 : 0));
            if (exp_i) pend_i = 0;
            if (exp_d) pend_d = 0;
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        test_reset();
        test_fetch_only();
        test_store();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_withdrawn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the pipelined RV32I core's instruction-fetch port and its data port. One access is granted per cycle, with data priority and a bounded-starvation guarantee for fetch. Each read response is routed back to its requester one cycle after its grant. The block sits between the `riscv` core top and a unified instruction/data SRAM.

## Interface
Parameters:
- `XLEN`, `` `XLEN `` (32): data and address width, taken from `RV32I_defines.v`.
- `STARVE_LIMIT`, 4: maximum consecutive data grants allowed while fetch waits. Legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request. Held until `i_gnt`.
- `i_addr` in XLEN: fetch address (PC).
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: fetch data valid.
- `i_rdata` out XLEN: fetch data.
- `d_req` in 1: data request. Held until `d_gnt`.
- `d_we` in 1: 1 = store.
- `d_addr` in XLEN: data address.
- `d_wdata` in XLEN: store data.
- `d_mask` in XLEN: bit-level write mask.
- `d_gnt` out 1: data access accepted.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out XLEN: load data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_addr` out XLEN: memory address.
- `mem_wdata` out XLEN: memory write data.
- `mem_mask` out XLEN: memory write mask.
- `mem_rdata` in XLEN: memory read data, valid the cycle after a read `mem_en`.

## Operation
- **Grant decision (combinational)**
  - Fetch gets the grant if `i_req` and either `!d_req` or `starve_cnt == STARVE_LIMIT`.
  - Otherwise data gets the grant if `d_req`.
  - At most one grant per cycle.
- **Memory outputs**
  - On a grant, the `mem_*` outputs mirror the winner. Fetch is always a read: `mem_we=0`, `mem_mask=0`.
  - With no grant, `mem_en=0`, `mem_we=0`, and `mem_addr`, `mem_wdata`, `mem_mask` are all 0.
- **Starvation counter `starve_cnt`**
  - Width `$clog2(STARVE_LIMIT+1)`.
  - Increments, saturating, when data is granted while `i_req=1`.
  - Clears to 0 on a fetch grant, or in any cycle with `i_req=0`.
- **Response FSM `resp_owner`** (states R_NONE, R_I, R_D), updated every cycle:
  - → R_I on a fetch grant.
  - → R_D on a data grant with `d_we=0`.
  - → R_NONE otherwise, including store grants.
- **Read data routing**
  - `i_rvalid = (resp_owner==R_I)`; `i_rdata = i_rvalid ? mem_rdata : 0`.
  - `d_rvalid` and `d_rdata` are defined the same way for R_D.
- **Stores**
  - Completion is `d_gnt` alone. No `d_rvalid` is generated.
- **Requester rules**
  - A requester must hold its request and payload stable until granted.
  - Dropping `req` before grant is legal: nothing is issued.

## Timing
- **Reset values.** While `reset=1`:
  - `i_gnt`, `d_gnt` and `mem_en` are forced to 0.
  - `resp_owner` and `starve_cnt` clear to R_NONE and 0 at the clock edge.
  - All outputs read 0 in the cycle after reset.
- **Grant latency.** 0 cycles: grant is in the same cycle as the request when it wins.
- **Read latency.** Data arrives exactly 1 cycle after the grant.
- **Throughput.** Back-to-back grants every cycle. Pipelined reads give one `rvalid` per cycle.
- **Simultaneous requests.** Data wins until `STARVE_LIMIT` consecutive data wins have occurred while fetch waits. The next cycle grants fetch.
- **Counter saturation.** `starve_cnt` never exceeds `STARVE_LIMIT`.
- **Reset mid-operation.** A read granted in the cycle before reset asserts produces no `rvalid`, because reset gates it in the same cycle. No grant is issued during reset.
- **No combinational loops.** `i_gnt`/`d_gnt` must not feed back into `*_req`.

## Structure
- **Shared package `mem_arb_pkg`:**
  - `resp_owner_t` enum {R_NONE, R_I, R_D}.
  - Default `STARVE_LIMIT`.
  - `` `XLEN `` comes from `RV32I_defines.v`.
- **Sub-module `mem_arb_pick`:** combinational priority/starvation grant picker. Inputs are `i_req`, `d_req` and `starve_cnt`; outputs are the two grant bits.
- **Top level:** holds the counter, the response FSM and the muxing.

## Test plan
- **Fetch only.** `i_req=1`, `i_addr=0x100`, memory returns 0x00000013.
  - Required: `i_gnt=1`, `mem_addr=0x100` that cycle; `i_rvalid=1`, `i_rdata=0x13` next cycle; `d_rvalid=0`.
- **Store.** `d_req=1`, `d_we=1`, `d_addr=0x200`, `d_wdata=0xDEADBEEF`, `d_mask=0x0000FFFF`.
  - Required: `mem_we=1`, `mem_mask=0x0000FFFF`; no `rvalid` on either port next cycle.
- **Contention with `STARVE_LIMIT=4`.** `i_req` and `d_req` both held high for 10 cycles.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I.
- **Back-to-back reads.** Grants D(0x300) then I(0x104).
  - Required: `d_rvalid` in cycle 1 and `i_rvalid` in cycle 2, each carrying its own `mem_rdata`.
- **Reset after a read grant.** Read granted in cycle 0, `reset=1` in cycle 1.
  - Required: no `rvalid` in cycle 1, all grants 0 during reset, `starve_cnt=0` afterward.
- **Request withdrawn.** `i_req` raised for one cycle while `d_req` wins, then dropped.
  - Required: fetch is never granted and `starve_cnt` returns to 0.
